// File: rtl/ps2_mouse_sequencer.sv
// ps2_mouse_sequencer: brings a PS/2 mouse out of reset (0xFF), checks the
// ACK / self-test / ID responses, enables data reporting (0xF4), retries on
// error or timeout, and then forwards the mouse byte stream to the decoder.
// Optional packet resynchronisation is compiled in with PS2_MOUSE_RESYNC_EN.
module ps2_mouse_sequencer #(
   parameter int ACK_TIMEOUT = 2_500_000,
   parameter int BAT_TIMEOUT = 25_000_000,
   parameter int MAX_RETRIES = 3,
   parameter int PACKET_GAP  = 50_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reinit,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   input  logic       rx_ready,
   input  logic [7:0] rx_byte,
   output logic       stream_valid,
   output logic [7:0] stream_byte,
   output logic       init_done,
   output logic       init_error,
   output logic [1:0] retry_count
);

   localparam int TMAX = (BAT_TIMEOUT > ACK_TIMEOUT) ? BAT_TIMEOUT : ACK_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0] BAT_LAST    = TW'(BAT_TIMEOUT - 1);
   localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRIES);

   typedef enum logic [3:0] {
      SEND_RST, ACK_RST, BAT, ID, SEND_EN, ACK_EN, RETRY, STREAM, FAIL
   } state_t;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [1:0]    retries_q;
   logic          stream_valid_q;
   logic [7:0]    stream_byte_q;
   logic          init_done_q;
   logic          init_error_q;

   logic          sendNow;
   logic          acceptByte;
   logic [7:0]    goodByte;
   logic [TW-1:0] timerLast;
   state_t        nextOk;

   // A command goes out in the same cycle a SEND state sees the transceiver
   // idle; reset and reinit suppress it because they redirect the FSM.
   assign sendNow  = !reset && !reinit && !tx_busy &&
                     ((state_q == SEND_RST) || (state_q == SEND_EN));
   assign tx_start = sendNow;
   assign tx_byte  = !sendNow ? 8'h00 : ((state_q == SEND_EN) ? 8'hF4 : 8'hFF);

   assign stream_valid = stream_valid_q;
   assign stream_byte  = stream_byte_q;
   assign init_done    = init_done_q;
   assign init_error   = init_error_q;
   assign retry_count  = retries_q;

   // Per wait state: the one response byte that lets bring-up progress,
   // where it leads, and the last timer value before the wait gives up.
   always_comb begin
      goodByte  = 8'hFA;
      timerLast = ACK_LAST;
      nextOk    = RETRY;
      case (state_q)
         ACK_RST: nextOk = BAT;
         BAT: begin
            goodByte  = 8'hAA;
            timerLast = BAT_LAST;
            nextOk    = ID;
         end
         ID: begin
            goodByte  = 8'h00;
            timerLast = BAT_LAST;
            nextOk    = SEND_EN;
         end
         ACK_EN: nextOk = STREAM;
         default: ;
      endcase
   end

`ifdef PS2_MOUSE_RESYNC_EN
   localparam int GW = $clog2(PACKET_GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(PACKET_GAP - 1);

   logic [1:0]    pos_q;
   logic [GW-1:0] gap_q;

   // Only a byte with bit 3 set may open a packet.
   assign acceptByte = (pos_q != 2'd0) || rx_byte[3];

   // Track the position inside the 3-byte packet and drop back to the packet
   // start when the mouse goes quiet in the middle of a packet.
   always_ff @(posedge clk) begin
      if (reset || reinit || (state_q != STREAM)) begin
         pos_q <= 2'd0;
         gap_q <= '0;
      end else if (rx_ready) begin
         gap_q <= '0;
         if (acceptByte) begin
            pos_q <= (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
         end
      end else if (pos_q != 2'd0) begin
         if (gap_q == GAP_LAST) begin
            pos_q <= 2'd0;
            gap_q <= '0;
         end else begin
            gap_q <= gap_q + GW'(1);
         end
      end
   end
`else
   assign acceptByte = 1'b1;
`endif

   // Bring-up FSM with timeout timer, retry counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= SEND_RST;
         timer_q        <= '0;
         retries_q      <= 2'd0;
         stream_valid_q <= 1'b0;
         stream_byte_q  <= 8'h00;
         init_done_q    <= 1'b0;
         init_error_q   <= 1'b0;
      end else begin
         stream_valid_q <= 1'b0;
         if (reinit) begin
            state_q      <= SEND_RST;
            timer_q      <= '0;
            retries_q    <= 2'd0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
         end else begin
            case (state_q)
               SEND_RST, SEND_EN: begin
                  if (!tx_busy) begin
                     state_q <= (state_q == SEND_RST) ? ACK_RST : ACK_EN;
                     timer_q <= '0;
                  end
               end
               ACK_RST, BAT, ID, ACK_EN: begin
                  if (rx_ready) begin
                     timer_q <= '0;
                     if (rx_byte == goodByte) begin
                        state_q <= nextOk;
                        if (nextOk == STREAM) begin
                           init_done_q <= 1'b1;
                        end
                     end else begin
                        state_q <= RETRY;
                     end
                  end else if (timer_q == timerLast) begin
                     state_q <= RETRY;
                     timer_q <= '0;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end
               RETRY: begin
                  if (retries_q == RETRY_LIMIT) begin
                     state_q      <= FAIL;
                     init_error_q <= 1'b1;
                  end else begin
                     retries_q <= retries_q + 2'd1;
                     state_q   <= SEND_RST;
                  end
               end
               STREAM: begin
                  if (rx_ready && acceptByte) begin
                     stream_valid_q <= 1'b1;
                     stream_byte_q  <= rx_byte;
                  end
               end
               FAIL: ;
               default: state_q <= SEND_RST;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// tb_ps2_mouse_sequencer: drives the sequencer like a PS/2 mouse would, with
// randomised response delays and faults, and scoreboards every command strobe
// and every forwarded stream byte against a bench-side model of bring-up.
module tb_ps2_mouse_sequencer;

   localparam int AckTo      = 40;
   localparam int BatTo      = 60;
   localparam int MaxRetries = 3;
   localparam int Gap        = 12;

   logic       clk = 1'b0;
   logic       reset;
   logic       reinit;
   logic       txBusy;
   logic       txStart;
   logic [7:0] txByte;
   logic       rxReady;
   logic [7:0] rxByte;
   logic       streamValid;
   logic [7:0] streamByte;
   logic       initDone;
   logic       initError;
   logic [1:0] retryCount;

   ps2_mouse_sequencer #(
      .ACK_TIMEOUT(AckTo),
      .BAT_TIMEOUT(BatTo),
      .MAX_RETRIES(MaxRetries),
      .PACKET_GAP (Gap)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .reinit      (reinit),
      .tx_busy     (txBusy),
      .tx_start    (txStart),
      .tx_byte     (txByte),
      .rx_ready    (rxReady),
      .rx_byte     (rxByte),
      .stream_valid(streamValid),
      .stream_byte (streamByte),
      .init_done   (initDone),
      .init_error  (initError),
      .retry_count (retryCount)
   );

   // 10-time-unit clock
   always #5 clk = ~clk;

   // Cycle index, advanced at every rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      int         when;
   } expect_t;

   expect_t txQ[$];
   expect_t streamQ[$];

   int checks = 0;
   int errors = 0;

   int modelRetries = 0;
   int modelPos     = 0;
   int lastStrobe   = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, required);
      end
   endtask

   task automatic failNow(input string name, input string detail);
      checks++;
      errors++;
      $display("[TB] FAIL %s: %s", name, detail);
   endtask

   task automatic finishRun();
      checkOutput("pending tx commands", txQ.size(), 0);
      checkOutput("pending stream bytes", streamQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Monitor: pops the scoreboard on every command strobe and stream strobe
   always @(negedge clk) begin
      expect_t e;
      if (txStart === 1'b1) begin
         checkOutput("tx_busy at tx_start", txBusy, 0);
         if (txQ.size() == 0) begin
            failNow("unexpected tx_start", $sformatf("byte %0h at cycle %0d", txByte, cyc));
         end else begin
            e = txQ.pop_front();
            checkOutput("tx_byte", txByte, e.data);
            if (e.when >= 0) checkOutput("tx_start cycle", cyc, e.when);
         end
      end
      if (streamValid === 1'b1) begin
         if (streamQ.size() == 0) begin
            failNow("unexpected stream_valid", $sformatf("byte %0h at cycle %0d", streamByte, cyc));
         end else begin
            e = streamQ.pop_front();
            checkOutput("stream_byte", streamByte, e.data);
            checkOutput("stream latency", cyc, e.when);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // One-cycle received-byte strobe from the transceiver
   task automatic applyStimulus(input logic [7:0] b);
      rxReady = 1'b1;
      rxByte  = b;
      step();
      rxReady = 1'b0;
      rxByte  = 8'($urandom);
   endtask

   task automatic expectTx(input logic [7:0] b, input int when);
      expect_t e;
      e.data = b;
      e.when = when;
      txQ.push_back(e);
   endtask

   task automatic waitTx();
      for (int i = 0; i < BatTo * 4; i++) begin
         #1;
         if (txStart === 1'b1) return;
         step();
      end
      failNow("tx_start wait", "no command strobe within the cycle budget");
      finishRun();
   endtask

   // A failed attempt: either give up (retries used up) or start over with FF
   task automatic handleFailure(output int status, output int nextWhen);
      nextWhen = -1;
      if (modelRetries == MaxRetries) begin
         step();
         checkOutput("init_error after exhaustion", initError, 1);
         checkOutput("retry_count at fail", retryCount, MaxRetries);
         checkOutput("init_done at fail", initDone, 0);
         status = 2;
      end else begin
         modelRetries++;
         if ($urandom_range(1, 0) == 1) applyStimulus(8'($urandom));
         else step();
         checkOutput("retry_count after failure", retryCount, modelRetries);
         checkOutput("init_error during retries", initError, 0);
         status   = 0;
         nextWhen = cyc;
      end
   endtask

   // One bring-up attempt. fault 0: clean; 1-4: wrong byte in response k;
   // 5-8: silence in response k-4; 9: reinit collides with the enable ACK.
   task automatic runAttempt(input int fault, input int badSel, input int txWhen,
                             output int status, output int nextWhen);
      logic [7:0] good [4];
      logic [7:0] bad;
      int lim;
      int d;
      int busyHold;
      good[0] = 8'hFA; good[1] = 8'hAA; good[2] = 8'h00; good[3] = 8'hFA;
      status   = 0;
      nextWhen = -1;
      busyHold = 0;
      expectTx(8'hFF, txWhen);
      waitTx();
      step();
      for (int ph = 0; ph < 4; ph++) begin
         lim = (ph == 1 || ph == 2) ? BatTo : AckTo;
         if (fault == ph + 5) begin
            idle(lim);
            handleFailure(status, nextWhen);
            return;
         end
         d = $urandom_range(lim - 1, 0);
         if ($urandom_range(3, 0) == 0) d = lim - 1;
         idle(d);
         if (fault == ph + 1) begin
            if (badSel >= 0) begin
               bad = 8'(badSel);
            end else begin
               bad = 8'($urandom);
               if ($urandom_range(1, 0) == 1) bad = (ph == 1) ? 8'hFC : 8'hFE;
               if (bad == good[ph]) bad = ~bad;
            end
            applyStimulus(bad);
            handleFailure(status, nextWhen);
            return;
         end
         if (fault == 9 && ph == 3) begin
            reinit = 1'b1;
            applyStimulus(good[ph]);
            reinit = 1'b0;
            modelRetries = 0;
            checkOutput("collision init_done", initDone, 0);
            checkOutput("collision retry_count", retryCount, 0);
            status   = 0;
            nextWhen = cyc;
            return;
         end
         if (ph == 2) begin
            busyHold = $urandom_range(3, 0);
            if (busyHold > 0) txBusy = 1'b1;
         end
         if (ph == 3) checkOutput("init_done before enable ack", initDone, 0);
         applyStimulus(good[ph]);
         if (ph == 2) begin
            if (busyHold > 0) begin
               idle(busyHold);
               txBusy = 1'b0;
            end
            expectTx(8'hF4, -1);
            waitTx();
            step();
         end
      end
      checkOutput("init_done after enable ack", initDone, 1);
      checkOutput("retry_count at stream", retryCount, modelRetries);
      checkOutput("init_error at stream", initError, 0);
      status     = 1;
      modelPos   = 0;
      lastStrobe = cyc;
   endtask

   task automatic randomBringUp(input int firstWhen, output int status);
      int when;
      int fault;
      when   = firstWhen;
      status = 0;
      while (status == 0) begin
         fault = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(8, 1);
         runAttempt(fault, -1, when, status, when);
      end
   endtask

   // Pulse reinit; returns the cycle in which FF is due
   task automatic doReinit(output int when);
      reinit = 1'b1;
      step();
      reinit = 1'b0;
      modelRetries = 0;
      checkOutput("init_done after reinit", initDone, 0);
      checkOutput("init_error after reinit", initError, 0);
      checkOutput("retry_count after reinit", retryCount, 0);
      when = cyc;
   endtask

   // Stream model: packets open only on bit 3 and restart after a long gap
   task automatic sendStream(input logic [7:0] b, input int gapBefore);
      expect_t e;
      bit accept;
      idle(gapBefore);
`ifdef PS2_MOUSE_RESYNC_EN
      if (modelPos != 0 && (cyc - lastStrobe - 1) >= Gap) modelPos = 0;
      accept = (modelPos != 0) || b[3];
      if (accept) modelPos = (modelPos + 1) % 3;
`else
      accept = 1'b1;
`endif
      if (accept) begin
         e.data = b;
         e.when = cyc + 1;
         streamQ.push_back(e);
      end
      lastStrobe = cyc;
      applyStimulus(b);
   endtask

   task automatic randomStream(input int n);
      int gaps [7];
      gaps[0] = 0; gaps[1] = 0; gaps[2] = 1; gaps[3] = 3;
      gaps[4] = Gap - 1; gaps[5] = Gap; gaps[6] = Gap + 1;
      for (int i = 0; i < n; i++) begin
         sendStream(8'($urandom), gaps[$urandom_range(6, 0)]);
      end
   endtask

   initial begin
      int status;
      int when;
      reset   = 1'b1;
      reinit  = 1'b0;
      txBusy  = 1'b1;
      rxReady = 1'b0;
      rxByte  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      checkOutput("reset tx_start", txStart, 0);
      checkOutput("reset tx_byte", txByte, 0);
      checkOutput("reset stream_valid", streamValid, 0);
      checkOutput("reset init_done", initDone, 0);
      checkOutput("reset init_error", initError, 0);
      checkOutput("reset retry_count", retryCount, 0);
      idle($urandom_range(5, 2));
      txBusy = 1'b0;

      $display("[TB] nominal bring-up");
      runAttempt(0, -1, -1, status, when);

      $display("[TB] stream forwarding and resync");
      sendStream(8'h08, 0);
      sendStream(8'h05, $urandom_range(2, 0));
      sendStream(8'h03, $urandom_range(2, 0));
      sendStream(8'h05, 1);
      sendStream(8'h09, 0);
      sendStream(8'h01, 0);
      sendStream(8'h02, 0);
      sendStream(8'h09, 0);
      sendStream(8'h01, Gap - 1);
      sendStream(8'h02, 0);
      sendStream(8'h09, 0);
      sendStream(8'h04, Gap);
      randomStream(30);
      idle(3);

      $display("[TB] resend handling");
      doReinit(when);
      runAttempt(1, 8'hFE, when, status, when);
      runAttempt(0, -1, when, status, when);

      $display("[TB] reinit collision");
      sendStream(8'h0C, 0);
      doReinit(when);
      runAttempt(2, -1, when, status, when);
      runAttempt(9, -1, when, status, when);
      runAttempt(0, -1, when, status, when);
      randomStream(6);
      idle(3);

      $display("[TB] randomised bring-ups");
      for (int r = 0; r < 8; r++) begin
         doReinit(when);
         randomBringUp(when, status);
         if (status == 1) randomStream(8);
         else for (int j = 0; j < 3; j++) applyStimulus(8'($urandom));
         idle(3);
      end

      $display("[TB] timeout exhaustion");
      doReinit(when);
      status = 0;
      while (status == 0) runAttempt(5, -1, when, status, when);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(8'($urandom));
         idle($urandom_range(3, 0));
      end
      checkOutput("init_error holds in fail", initError, 1);
      checkOutput("retry_count holds in fail", retryCount, MaxRetries);

      $display("[TB] recovery from fail");
      doReinit(when);
      runAttempt(0, -1, when, status, when);
      randomStream(6);
      idle(4);
      finishRun();
   end

endmodule

// File: doc/ps2_mouse_sequencer.md
# ps2_mouse_sequencer

Brings up a PS/2 mouse after reset and gates its data stream. It sits between the PS/2 host transceiver (byte transmitter plus received-byte strobe) and the mouse packet decoder. It sends the reset and enable-data-reporting commands, checks every mouse response, and retries on error or timeout. Once the mouse is streaming, it forwards received bytes to the decoder as a clean, packet-aligned byte stream.

## Interface
- `ACK_TIMEOUT`, 2_500_000: cycles allowed for an ACK after a command is issued.
- `BAT_TIMEOUT`, 25_000_000: cycles allowed for the self-test result (0xAA) and for the device ID.
- `MAX_RETRIES`, 3: failed attempts tolerated before the FAIL state.
- `PACKET_GAP`, 50_000: maximum cycles allowed between bytes of one packet (used only when resync is compiled in).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `reinit` in 1: one-cycle pulse that restarts initialization.
- `tx_busy` in 1: high while the transceiver is sending or inhibited.
- `tx_start` out 1: one-cycle command strobe.
- `tx_byte` out 8: command byte, valid while `tx_start` is high.
- `rx_ready` in 1: one-cycle strobe for a received byte.
- `rx_byte` in 8: received byte, valid while `rx_ready` is high.
- `stream_valid` out 1: one-cycle strobe to the packet decoder.
- `stream_byte` out 8: forwarded byte.
- `init_done` out 1: high while in STREAM.
- `init_error` out 1: high while in FAIL.
- `retry_count` out 2: failed attempts so far; saturates at 3.

## Operation
- **Reset values:** all outputs are 0, state = SEND_RST, timer = 0, retries = 0, packet position = 0.
- **SEND_RST:** when `tx_busy`=0, pulse `tx_start` with `tx_byte`=0xFF, then go to ACK_RST. Timer cleared.
- **ACK_RST:**
  - 0xFA → BAT.
  - 0xFE, any other byte, or timer = ACK_TIMEOUT-1 → RETRY.
- **BAT:**
  - 0xAA → ID.
  - 0xFC, any other byte, or timer = BAT_TIMEOUT-1 → RETRY.
- **ID:**
  - 0x00 → SEND_EN.
  - Any other byte, or BAT_TIMEOUT expiry → RETRY.
- **SEND_EN:** when `tx_busy`=0, pulse `tx_start` with `tx_byte`=0xF4, then go to ACK_EN.
- **ACK_EN:**
  - 0xFA → STREAM.
  - 0xFE, any other byte, or ACK_TIMEOUT expiry → RETRY.
- **RETRY** (one cycle):
  - If retries = MAX_RETRIES → FAIL.
  - Otherwise increment retries and go to SEND_RST. A failed enable also restarts the full sequence.
- **STREAM:** every `rx_ready` is forwarded. The timer is unused.
- **FAIL:** terminal. Only `reset` or `reinit` leaves FAIL.
- **reinit:** from any state, go to SEND_RST with retries = 0 and packet position = 0. It has priority over `rx_ready` and over timeout in the same cycle.
- **Timer:** cleared on every state change and incremented every cycle in the wait states.
- **rx_ready coinciding with timer expiry:** the received byte is evaluated and the timeout is ignored.
- **rx_ready outside STREAM and outside the wait states** (SEND_*, RETRY, FAIL): the byte is dropped.
- **tx_busy:** a command is never issued while `tx_busy`=1; the sequencer holds in SEND_* until it clears.

## Timing
- `tx_start` is high for exactly the one cycle in which SEND_* sees `tx_busy`=0. The wait state starts on the next cycle.
- Stream latency: `rx_ready` in cycle N gives `stream_valid` in cycle N+1, with `stream_byte` registered.
- `init_done` rises on the cycle after the ACK_EN 0xFA strobe and falls on the cycle after `reinit`.
- Fastest bring-up is 2 commands plus 4 responses. There is no fixed latency; progress is driven by the device.

## Configuration
- **With `PS2_MOUSE_RESYNC_EN` defined:** STREAM tracks a packet position of 0 to 2.
  - At position 0, a byte with bit 3 = 0 is discarded: no `stream_valid`, position stays 0.
  - Accepted bytes advance the position 0→1→2→0.
  - If PACKET_GAP cycles pass at position 1 or 2 without `rx_ready`, the position returns to 0.
- **Without it:** every STREAM byte is forwarded unchanged. No position or gap logic is present.

## Test plan
- **Nominal bring-up:** `tx_busy`=0; responses FA, AA, 00, then FA.
  - `tx_byte` FF, then F4, each with a single `tx_start`.
  - `init_done`=1 with `retry_count`=0.
- **Resend handling:** FE in place of the first FA.
  - `retry_count`=1.
  - FF is reissued, then the nominal sequence completes.
- **Timeout exhaustion:** no responses at all.
  - FF is sent 4 times, each ACK_TIMEOUT cycles apart.
  - `retry_count`=3, then `init_error`=1. Further `rx_ready` strobes are ignored.
- **Stream forwarding:** in STREAM, send 08, 05, 03.
  - Three `stream_valid` strobes, one cycle after each `rx_ready`, carrying the same bytes.
- **Resync** (macro on): in STREAM, send 05, then 09, 01, 02.
  - 05 is dropped; 09, 01, 02 are forwarded.
  - Send 09, wait PACKET_GAP+1 cycles, then send 04: 04 is dropped.
- **reinit collision:** `reinit` and `rx_ready`=FA in the same cycle during ACK_EN.
  - Next state is SEND_RST with `retry_count`=0 and `init_done`=0.
  - The FA is not used to complete ACK_EN.
